// File: rtl/aria_sublayer.sv
// ARIA substitution layer (SL1/SL2): substitutes one 128-bit state, one 32-bit word per cycle,
// through four byte lanes each built from a GF(2^8) inverter wrapped by ARIA affine transforms.

package aria_gf_pkg;
  // Columns of the linear parts, column j (input bit j) in byte j.
  localparam logic [63:0] B_COLS    = 64'hEE855F5B_CF12C5AC;
  localparam logic [63:0] BINV_COLS = 64'hEF4217C7_C930C39F;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (aa & {8{b[i]}});
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] x);
    return gf_mul(x, x);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] mat_mul(input logic [63:0] cols, input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int j = 0; j < 8; j++) begin
      r = r ^ (cols[8*j +: 8] & {8{x[j]}});
    end
    return r;
  endfunction
endpackage

module gf256_inv (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  import aria_gf_pkg::*;
  logic [7:0] x2_s, x3_s, x12_s, x15_s, x240_s;

  // Addition chain for x^254 (inv(0) falls out as 0).
  always_comb begin
    x2_s   = gf_sq(din);
    x3_s   = gf_mul(x2_s, din);
    x12_s  = gf_sq(gf_sq(x3_s));
    x15_s  = gf_mul(x12_s, x3_s);
    x240_s = gf_sq(gf_sq(gf_sq(gf_sq(x15_s))));
    dout   = gf_mul(gf_mul(x240_s, x12_s), x2_s);
  end
endmodule

module aria_sublayer_lane (
  input  logic [7:0] din,
  input  logic [1:0] role,
  output logic [7:0] dout
);
  import aria_gf_pkg::*;
  logic [7:0] pre_s;
  logic [7:0] inv_s;

  // Role 0=S1, 1=S2, 2=X1, 3=X2; inverse boxes transform before inversion, forward boxes after.
  always_comb begin
    pre_s = din;
    case (role)
      2'd2:    pre_s = rotl8(din ^ 8'h63, 1) ^ rotl8(din ^ 8'h63, 3) ^ rotl8(din ^ 8'h63, 6);
      2'd3:    pre_s = gf_sq(gf_sq(gf_sq(gf_sq(gf_sq(mat_mul(BINV_COLS, din ^ 8'hE2))))));
      default: pre_s = din;
    endcase
  end

  gf256_inv u_inv (.din(pre_s), .dout(inv_s));

  // Forward-box post transforms.
  always_comb begin
    dout = inv_s;
    case (role)
      2'd0:    dout = inv_s ^ rotl8(inv_s, 1) ^ rotl8(inv_s, 2) ^ rotl8(inv_s, 3)
                      ^ rotl8(inv_s, 4) ^ 8'h63;
      2'd1:    dout = mat_mul(B_COLS, gf_sq(gf_sq(gf_sq(inv_s)))) ^ 8'hE2;
      default: dout = inv_s;
    endcase
  end
endmodule

module aria_sublayer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_type,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [1:0]    wcnt_r;
  logic [127:0]  in_r;
  logic          type_r;
  logic [127:0]  out_r;
  logic [31:0]   word_s;
  logic [31:0]   sub_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = in_valid ? BUSY : IDLE;
      BUSY:    state_s = (wcnt_r == 2'd3) ? DONE : BUSY;
      DONE:    state_s = out_ready ? IDLE : DONE;
      default: state_s = IDLE;
    endcase
  end

  // Word currently being substituted, always taken from the latched block.
  always_comb begin
    word_s = 32'h0000_0000;
    case (wcnt_r)
      2'd0:    word_s = in_r[127:96];
      2'd1:    word_s = in_r[95:64];
      2'd2:    word_s = in_r[63:32];
      2'd3:    word_s = in_r[31:0];
      default: word_s = 32'h0000_0000;
    endcase
  end

  // Byte position k of every word has the same role; SL2 swaps forward and inverse boxes.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    localparam logic [1:0] POS = 2'(k);
    aria_sublayer_lane u_lane (
      .din  (word_s[31-8*k -: 8]),
      .role ({POS[1] ^ type_r, POS[0]}),
      .dout (sub_s[31-8*k -: 8])
    );
  end

  // Input latch, word counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_r   <= 128'd0;
      type_r <= 1'b0;
      wcnt_r <= 2'd0;
      out_r  <= 128'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            in_r   <= in_data;
            type_r <= in_type;
            wcnt_r <= 2'd0;
          end
        end
        BUSY: begin
          wcnt_r <= wcnt_r + 2'd1;
          case (wcnt_r)
            2'd0:    out_r[127:96] <= sub_s;
            2'd1:    out_r[95:64]  <= sub_s;
            2'd2:    out_r[63:32]  <= sub_s;
            default: out_r[31:0]   <= sub_s;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign out_data  = out_r;
endmodule
